sp_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request interface, a configurable registered read latency and a hardware clear sequencer. It replaces fixed 32x8 scratch RAMs in the datapath. It adds three things the fixed RAMs lack: a defined power-up content, byte-lane writes, and read-data valid signalling.

---
 rtl/sp_ram_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sp_ram_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: parametrised single-port synchronous RAM with a valid/ready request
// port, byte-lane writes, a registered read pipeline (1 or 2 cycles) and a hardware
// clear sequencer that sweeps CLEAR_VAL through every word after reset and on demand.
// Optional feature macro: SP_RAM_PARITY_EN (per-lane even parity, reported on par_err).
module sp_ram_ctrl #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DEPTH      = 32,
    parameter int unsigned       RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                clear_start,
    output logic                busy,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                rd_err,
    output logic                par_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StInitClear,
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_en;

    logic              accept;
    logic              addr_ok;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] rd_word;
    logic              par_bad;

    logic [DATA_W-1:0] mem [DEPTH];

    // State register: sweep pointer and FSM state, reset restarts the sweep at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInitClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: sweep to DEPTH-1 then idle; clear_start only honoured in idle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StInitClear, StClear: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StIdle: begin
                if (clear_start) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StInitClear;
                ptr_d   = '0;
            end
        endcase
    end

    // Output logic: requests are only accepted while no sweep is running
    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        clr_en    = (state_q != StIdle);
    end

    assign accept  = req_valid & req_ready;
    // Widened compare so DEPTH == 2**ADDR_W never reports out of range
    assign addr_ok = ({1'b0, address} < DEPTH_EXT);
    assign wr_en   = accept & req_write & addr_ok;
    assign rd_en   = accept & ~req_write;
    assign req_idx = address[IDX_W-1:0];
    assign clr_idx = ptr_q[IDX_W-1:0];
    assign rd_word = addr_ok ? mem[req_idx] : '0;

    // Array write port: clear sweep has the port, otherwise per-lane request writes
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= CLEAR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[req_idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

    // Parity storage tracks the data array lane by lane
    always_ff @(posedge clk) begin
        if (clr_en) begin
            par_mem[clr_idx] <= lane_par(CLEAR_VAL);
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    par_mem[req_idx][i] <= ^data_in[8*i +: 8];
                end
            end
        end
    end

    assign par_bad = addr_ok & (|(lane_par(mem[req_idx]) ^ par_mem[req_idx]));
`else
    assign par_bad = 1'b0;
`endif

    logic              v1_q;
    logic              err1_q;
    logic              par1_q;
    logic [DATA_W-1:0] d1_q;

    // First read stage: array sampled on the accept edge; data only updates on reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
            par1_q <= 1'b0;
            d1_q   <= '0;
        end else begin
            v1_q   <= rd_en;
            err1_q <= rd_en & ~addr_ok;
            par1_q <= rd_en & par_bad;
            if (rd_en) begin
                d1_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic              v2_q;
        logic              err2_q;
        logic              par2_q;
        logic [DATA_W-1:0] d2_q;

        // Extra output stage; holds data between valid pulses
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2_q   <= 1'b0;
                err2_q <= 1'b0;
                par2_q <= 1'b0;
                d2_q   <= '0;
            end else begin
                v2_q   <= v1_q;
                err2_q <= err1_q;
                par2_q <= par1_q;
                if (v1_q) begin
                    d2_q <= d1_q;
                end
            end
        end

        assign rd_valid = v2_q;
        assign rd_err   = err2_q;
        assign par_err  = par2_q;
        assign data_out = d2_q;
    end else begin : g_lat1
        assign rd_valid = v1_q;
        assign rd_err   = err1_q;
        assign par_err  = par1_q;
        assign data_out = d1_q;
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: instance A uses defaults (8b x 32, latency 1, clear 0),
// instance B uses 16b x 20, latency 2, clear 16'hA5C3. Reads push expected words
// into per-instance queues; negedge monitors pop and compare with latency stamps.
module tb_sp_ram_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        par;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [15:0] lasta, lastb;

    logic [7:0]  ma [32];
    logic [15:0] mb [20];

    // Instance A signals
    logic       a_valid, a_ready, a_write, a_clr, a_busy, a_rdv, a_err, a_par;
    logic [4:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic [0:0] a_be;

    // Instance B signals
    logic        b_valid, b_ready, b_write, b_clr, b_busy, b_rdv, b_err, b_par;
    logic [4:0]  b_addr;
    logic [15:0] b_din, b_dout;
    logic [1:0]  b_be;

    sp_ram_ctrl dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_valid),
        .req_ready  (a_ready),
        .req_write  (a_write),
        .address    (a_addr),
        .data_in    (a_din),
        .byte_en    (a_be),
        .clear_start(a_clr),
        .busy       (a_busy),
        .data_out   (a_dout),
        .rd_valid   (a_rdv),
        .rd_err     (a_err),
        .par_err    (a_par)
    );

    sp_ram_ctrl #(
        .DATA_W    (16),
        .ADDR_W    (5),
        .DEPTH     (20),
        .RD_LATENCY(2),
        .CLEAR_VAL (16'hA5C3)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_valid),
        .req_ready  (b_ready),
        .req_write  (b_write),
        .address    (b_addr),
        .data_in    (b_din),
        .byte_en    (b_be),
        .clear_start(b_clr),
        .busy       (b_busy),
        .data_out   (b_dout),
        .rd_valid   (b_rdv),
        .rd_err     (b_err),
        .par_err    (b_par)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_op(input logic w, input int addr, input logic [7:0] d,
                        input logic be, input logic clr = 1'b0, input logic par = 1'b0);
        chk("a_ready_at_req", {31'b0, a_ready}, 32'd1);
        a_valid = 1'b1; a_write = w; a_addr = 5'(addr); a_din = d; a_be = be; a_clr = clr;
        if (w) begin
            if (be) ma[addr] = d;
        end else begin
            qa.push_back('{data: {8'h00, ma[addr]}, err: 1'b0, par: par, cyc: cyc + 1});
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_clr = 1'b0;
    endtask

    task automatic b_op(input logic w, input int addr, input logic [15:0] d,
                        input logic [1:0] be);
        chk("b_ready_at_req", {31'b0, b_ready}, 32'd1);
        b_valid = 1'b1; b_write = w; b_addr = 5'(addr); b_din = d; b_be = be;
        if (w) begin
            if (addr < 20) begin
                for (int i = 0; i < 2; i++) if (be[i]) mb[addr][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            qb.push_back('{data: (addr < 20) ? mb[addr] : 16'h0000, err: (addr >= 20),
                           par: 1'b0, cyc: cyc + 2});
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    // Counts busy and not-ready cycles until both instances idle (bounded)
    task automatic count_busy(output int na, output int nra, output int nb, output int nrb);
        na = 0; nra = 0; nb = 0; nrb = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (a_ready) a_valid = 1'b0;
            if (!a_busy && !b_busy) break;
            if (a_busy) na++;
            if (!a_ready) nra++;
            if (b_busy) nb++;
            if (!b_ready) nrb++;
            if (na == 5) a_clr = 1'b1;
            if (na == 6) a_clr = 1'b0;
        end
    endtask

    // Monitor A: pop on rd_valid, otherwise data must hold and flags stay low
    always @(negedge clk) begin
        if (!reset) begin
            if (a_rdv) begin
                chk("a_pending", {31'b0, (qa.size() > 0)}, 32'd1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_data", {24'b0, a_dout}, {16'b0, ea.data});
                    chk("a_err", {31'b0, a_err}, {31'b0, ea.err});
                    chk("a_par", {31'b0, a_par}, {31'b0, ea.par});
                    chk("a_latency", cyc, ea.cyc);
                    lasta = ea.data;
                end
            end else begin
                chk("a_hold", {24'b0, a_dout}, {16'b0, lasta});
                chk("a_flags_idle", {30'b0, a_err, a_par}, 32'd0);
            end
        end
    end

    // Monitor B: same contract at latency 2
    always @(negedge clk) begin
        if (!reset) begin
            if (b_rdv) begin
                chk("b_pending", {31'b0, (qb.size() > 0)}, 32'd1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_data", {16'b0, b_dout}, {16'b0, eb.data});
                    chk("b_err", {31'b0, b_err}, {31'b0, eb.err});
                    chk("b_par", {31'b0, b_par}, {31'b0, eb.par});
                    chk("b_latency", cyc, eb.cyc);
                    lastb = eb.data;
                end
            end else begin
                chk("b_hold", {16'b0, b_dout}, {16'b0, lastb});
                chk("b_flags_idle", {30'b0, b_err, b_par}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int na, nra, nb, nrb;
        reset = 1'b1;
        a_valid = 0; a_write = 0; a_addr = 0; a_din = 0; a_be = 0; a_clr = 0;
        b_valid = 0; b_write = 0; b_addr = 0; b_din = 0; b_be = 0; b_clr = 0;
        lasta = 0; lastb = 0;
        for (int i = 0; i < 32; i++) ma[i] = 8'h00;
        for (int i = 0; i < 20; i++) mb[i] = 16'hA5C3;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_rst_outs", {a_dout, a_rdv, a_err, a_par, a_ready, a_busy}, {8'h00, 5'b00001});
        chk("b_rst_outs", {b_dout, b_rdv, b_err, b_par, b_ready, b_busy}, {16'h0000, 5'b00001});

        // Power-up sweep lengths
        @(posedge clk); #1 reset = 1'b0;
        count_busy(na, nra, nb, nrb);
        chk("a_init_busy", na, 32); chk("a_init_notready", nra, 32);
        chk("b_init_busy", nb, 20); chk("b_init_notready", nrb, 20);

        // A: basic read/write, boundaries, byte_en = 0 no-op
        a_op(0, 7, 8'h00, 1'b0);
        a_op(1, 3, 8'hA5, 1'b1);
        a_op(0, 3, 8'h00, 1'b0);
        a_op(1, 31, 8'h3C, 1'b1);
        a_op(0, 31, 8'h00, 1'b0);
        a_op(1, 3, 8'hFF, 1'b0);
        a_op(0, 3, 8'h00, 1'b0);
        a_op(0, 0, 8'h00, 1'b0);

        // A: fill, then read in flight with clear_start in the same cycle
        for (int i = 0; i < 32; i++) a_op(1, i, 8'(i * 7 + 1), 1'b1);
        a_op(0, 9, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) ma[i] = 8'h00;
        a_valid = 1'b1; a_write = 1'b1; a_addr = 5'd2; a_din = 8'hFF; a_be = 1'b1;
        count_busy(na, nra, nb, nrb);
        chk("a_clear_busy", na, 32); chk("a_clear_notready", nra, 32);
        chk("b_idle_during_a_clear", nb, 0);
        @(posedge clk); #1;
        a_op(0, 0, 8'h00, 1'b0);
        a_op(0, 2, 8'h00, 1'b0);
        a_op(0, 9, 8'h00, 1'b0);
        a_op(0, 31, 8'h00, 1'b0);

        // Reset part-way through a clear, with a B read in flight
        a_op(1, 31, 8'h22, 1'b1);
        b_op(1, 15, 16'h0F0F, 2'b11);
        a_clr = 1'b1; @(posedge clk); #1 a_clr = 1'b0;
        repeat (8) @(posedge clk); #1;
        b_op(0, 3, 16'h0000, 2'b00);
        reset = 1'b1;
        qa.delete(); qb.delete(); lasta = 0; lastb = 0;
        @(negedge clk);
        chk("a_midclear_rst", {a_ready, a_busy, a_rdv}, 3'b010);
        chk("b_midread_rst", {b_ready, b_busy, b_rdv}, 3'b010);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) ma[i] = 8'h00;
        for (int i = 0; i < 20; i++) mb[i] = 16'hA5C3;
        count_busy(na, nra, nb, nrb);
        chk("a_restart_busy", na, 32); chk("b_restart_busy", nb, 20);
        a_op(0, 31, 8'h00, 1'b0);
        b_op(0, 15, 16'h0000, 2'b00);

        // B: byte lanes, out-of-range, back-to-back reads at latency 2
        b_op(1, 4, 16'hFFFF, 2'b11);
        b_op(1, 4, 16'h1234, 2'b10);
        b_op(0, 4, 16'h0000, 2'b00);
        b_op(1, 25, 16'h0055, 2'b11);
        b_op(1, 20, 16'h0077, 2'b11);
        b_op(0, 25, 16'h0000, 2'b00);
        b_op(0, 20, 16'h0000, 2'b00);
        b_op(0, 19, 16'h0000, 2'b00);
        b_op(0, 9, 16'h0000, 2'b00);
        b_op(0, 5, 16'h0000, 2'b00);
        b_op(1, 0, 16'h1111, 2'b11);
        b_op(1, 1, 16'h2222, 2'b11);
        b_op(1, 2, 16'h3333, 2'b11);
        b_op(1, 1, 16'hBEEF, 2'b00);
        b_op(0, 0, 16'h0000, 2'b00);
        b_op(0, 1, 16'h0000, 2'b00);
        b_op(0, 2, 16'h0000, 2'b00);
        repeat (4) @(posedge clk); #1;
        b_op(0, 4, 16'h0000, 2'b00);

`ifdef SP_RAM_PARITY_EN
        // Flip one stored bit behind the parity store's back
        a_op(1, 4, 8'h5A, 1'b1);
        dut_a.mem[4] = 8'h5B;
        ma[4] = 8'h5B;
        a_op(0, 4, 8'h00, 1'b0, 1'b0, 1'b1);
        a_op(0, 3, 8'h00, 1'b0);
`endif

        repeat (5) @(posedge clk); #1;
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
